// File: rtl/sdft_pkg.sv
// ---------------------------------------------------------------------------
// sdft_pkg
// Definitions shared by the sliding-DFT core, freq_bram and the spectrum
// sequencer: bin count, bin data width, bin index width and the sequencer
// state encoding.
// ---------------------------------------------------------------------------
package sdft_pkg;

    localparam int FREQ_BINS   = 16;
    localparam int FREQ_DATA_W = 16;
    localparam int BIN_W       = $clog2(FREQ_BINS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SWAIT  = 3'd2,
        ST_READ   = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_SQUARE = 3'd5,
        ST_SUM    = 3'd6,
        ST_WRITE  = 3'd7
    } state_t;

endpackage

// File: rtl/mag_sq_clip.sv
// ---------------------------------------------------------------------------
// mag_sq_clip
// Two-stage squared-magnitude pipeline: stage 1 squares re and im, stage 2
// sums them at full width, shifts right by MAG_SHIFT and saturates to
// MAG_MAX. The result register holds its value until the next valid word.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   en       in   re/im valid, launches one word into stage 1
//   re, im   in   signed FREQ_DATA_W bin components
//   mag      out  clipped magnitude, zero-extended to FREQ_DATA_W
// ---------------------------------------------------------------------------
module mag_sq_clip #(
    parameter int FREQ_DATA_W = 16,
    parameter int MAG_SHIFT   = 8,
    parameter int MAG_MAX     = 639
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic signed [FREQ_DATA_W-1:0] re,
    input  logic signed [FREQ_DATA_W-1:0] im,
    output logic        [FREQ_DATA_W-1:0] mag
);

    localparam int SQ_W  = 2 * FREQ_DATA_W;
    localparam int SUM_W = SQ_W + 1;

    function automatic logic [FREQ_DATA_W-1:0] sat_mag(input logic [SUM_W-1:0] s);
        if (s > SUM_W'(MAG_MAX))
            return FREQ_DATA_W'(MAG_MAX);
        else
            return s[FREQ_DATA_W-1:0];
    endfunction

    logic signed [SQ_W-1:0]  w_sq_re_p0;
    logic signed [SQ_W-1:0]  w_sq_im_p0;
    logic        [SQ_W-1:0]  r_sq_re_p1;
    logic        [SQ_W-1:0]  r_sq_im_p1;
    logic                    r_vld_p1;
    logic        [SUM_W-1:0] w_sum_p1;
    logic        [FREQ_DATA_W-1:0] r_mag_p2;

    // (-2**(W-1))**2 = 2**(2W-2) still fits a 2W-bit square, so each square is
    // non-negative and can be treated as unsigned from here on.
    assign w_sq_re_p0 = SQ_W'(re) * SQ_W'(re);
    assign w_sq_im_p0 = SQ_W'(im) * SQ_W'(im);

    // ---- stage p0 -> p1: square ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_vld_p1 <= 1'b0;
        else
            r_vld_p1 <= en;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_sq_re_p1 <= w_sq_re_p0;
            r_sq_im_p1 <= w_sq_im_p0;
        end
    end

    // Extra bit keeps the sum of two maximal squares exact before the shift.
    assign w_sum_p1 = {1'b0, r_sq_re_p1} + {1'b0, r_sq_im_p1};

    // ---- stage p1 -> p2: sum, shift, saturate ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_mag_p2 <= '0;
        else if (r_vld_p1)
            r_mag_p2 <= sat_mag(w_sum_p1 >> MAG_SHIFT);
    end

    assign mag = r_mag_p2;

endmodule

// File: rtl/sdft_spectrum_ctrl.sv
// ---------------------------------------------------------------------------
// sdft_spectrum_ctrl
// Sequencer between the ADC, the sliding-DFT core and freq_bram. Feeds one
// ADC sample per start/ready handshake; every 2**UPDATE_W samples it stops
// sampling, reads every bin in ascending order and writes the clipped
// squared magnitude of each bin into freq_bram.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   adc                   raw ADC sample
//   sample                sample held for the core
//   fft_start / fft_read  one-cycle pulses to the core
//   fft_ready             core idle / bin data valid
//   bin_real / bin_imag   signed bin components from the core
//   bram_w_en/_addr/d_in  freq_bram write port
//   sweep_done            one-cycle pulse after the last bin write
// ---------------------------------------------------------------------------
module sdft_spectrum_ctrl #(
    parameter int  FREQ_BINS   = sdft_pkg::FREQ_BINS,
    parameter int  DATA_W      = 8,
    parameter int  FREQ_DATA_W = sdft_pkg::FREQ_DATA_W,
    parameter int  UPDATE_W    = 11,
    parameter int  MAG_SHIFT   = 8,
    parameter int  MAG_MAX     = 639,
    localparam int BIN_W       = $clog2(FREQ_BINS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic        [DATA_W-1:0]      adc,
    output logic        [DATA_W-1:0]      sample,
    output logic                          fft_start,
    output logic                          fft_read,
    input  logic                          fft_ready,
    input  logic signed [FREQ_DATA_W-1:0] bin_real,
    input  logic signed [FREQ_DATA_W-1:0] bin_imag,
    output logic                          bram_w_en,
    output logic        [BIN_W:0]         bram_w_addr,
    output logic        [FREQ_DATA_W-1:0] bram_d_in,
    output logic                          sweep_done
);

    import sdft_pkg::*;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [UPDATE_W-1:0]           r_smp_cnt;
    logic [BIN_W-1:0]              r_bin;
    logic                          r_skip;
    logic                          r_done;
    logic [DATA_W-1:0]             r_sample;
    logic signed [FREQ_DATA_W-1:0] r_re;
    logic signed [FREQ_DATA_W-1:0] r_im;
    logic                          w_last_bin;
    logic                          w_capture;

    assign w_last_bin = (r_bin == BIN_W'(FREQ_BINS - 1));
    // The core drops ready one cycle late, so the first wait cycle is ignored.
    assign w_capture  = (r_state == ST_RWAIT) && !r_skip && fft_ready;

    always_comb begin
        w_state_nxt = r_state;
        fft_start   = 1'b0;
        fft_read    = 1'b0;
        bram_w_en   = 1'b0;
        case (r_state)
            ST_IDLE:   if (fft_ready) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: begin
                fft_start   = 1'b1;
                w_state_nxt = ST_SWAIT;
            end
            // Counter at zero here means this sample completed a batch.
            ST_SWAIT:  if (!r_skip && fft_ready)
                           w_state_nxt = (r_smp_cnt == '0) ? ST_READ : ST_IDLE;
            ST_READ:   begin
                fft_read    = 1'b1;
                w_state_nxt = ST_RWAIT;
            end
            ST_RWAIT:  if (w_capture) w_state_nxt = ST_SQUARE;
            ST_SQUARE: w_state_nxt = ST_SUM;
            ST_SUM:    w_state_nxt = ST_WRITE;
            ST_WRITE:  begin
                bram_w_en   = 1'b1;
                w_state_nxt = w_last_bin ? ST_IDLE : ST_READ;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_smp_cnt <= '0;
            r_bin     <= '0;
            r_skip    <= 1'b0;
            r_done    <= 1'b0;
            r_sample  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= (r_state == ST_SAMPLE) || (r_state == ST_READ);
            r_done  <= (r_state == ST_WRITE) && w_last_bin;
            if ((r_state == ST_IDLE) && fft_ready)
                r_sample <= adc;
            if (r_state == ST_SAMPLE)
                r_smp_cnt <= r_smp_cnt + 1'b1;
            if (r_state == ST_WRITE)
                r_bin <= w_last_bin ? '0 : r_bin + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_re <= bin_real;
            r_im <= bin_imag;
        end
    end

    // SQUARE launches the captured bin; the magnitude lands at the end of SUM.
    mag_sq_clip #(
        .FREQ_DATA_W (FREQ_DATA_W),
        .MAG_SHIFT   (MAG_SHIFT),
        .MAG_MAX     (MAG_MAX)
    ) u_mag (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (r_state == ST_SQUARE),
        .re      (r_re),
        .im      (r_im),
        .mag     (bram_d_in)
    );

    assign sample      = r_sample;
    assign sweep_done  = r_done;
    assign bram_w_addr = {1'b0, r_bin};

endmodule

// File: tb/tb_sdft_spectrum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdft_spectrum_ctrl
// Two sequencer instances (MAG_SHIFT 0 and 8, UPDATE_W 3), each driven by a
// behavioural sdft core: ready drops one cycle after start/read and returns
// three cycles later; bin k returns re=k, im=0 unless overridden.
// ---------------------------------------------------------------------------
module tb_sdft_spectrum_ctrl;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [7:0] adc = 8'h00;
    logic signed [15:0] ov_re [2][16];
    logic signed [15:0] ov_im [2][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic               fft_start, fft_read, fft_ready, bram_w_en, sweep_done;
        logic [7:0]         sample;
        logic signed [15:0] bin_real, bin_imag;
        logic [4:0]         bram_w_addr;
        logic [15:0]        bram_d_in;
        logic [2:0]         busy;
        logic [3:0]         ridx, cur;

        sdft_spectrum_ctrl #(
            .FREQ_BINS(16), .DATA_W(8), .FREQ_DATA_W(16), .UPDATE_W(3),
            .MAG_SHIFT(g == 0 ? 0 : 8), .MAG_MAX(639)
        ) u_dut (
            .clk(clk), .reset_n(rst_n[g]), .adc(adc), .sample(sample),
            .fft_start(fft_start), .fft_read(fft_read), .fft_ready(fft_ready),
            .bin_real(bin_real), .bin_imag(bin_imag), .bram_w_en(bram_w_en),
            .bram_w_addr(bram_w_addr), .bram_d_in(bram_d_in), .sweep_done(sweep_done)
        );

        always @(posedge clk or negedge rst_n[g]) begin
            if (!rst_n[g]) begin
                busy <= 3'd0;
                ridx <= 4'd0;
                cur  <= 4'd0;
            end else begin
                if (fft_start || fft_read) busy <= 3'd4;
                else if (busy != 3'd0)     busy <= busy - 3'd1;
                if (fft_read) begin
                    cur  <= ridx;
                    ridx <= ridx + 4'd1;
                end
            end
        end
        assign fft_ready = !(busy == 3'd1 || busy == 3'd2 || busy == 3'd3);
        assign bin_real  = ov_re[g][cur];
        assign bin_imag  = ov_im[g][cur];
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_start[2], n_read[2], st_pre_rd[2], st_in_sw[2], n_done[2], done_c[2];
    int ovl[2], cons_st[2], cons_rd[2], wr_n[2];
    bit in_sweep[2], prev_st[2], prev_rd[2];
    logic [4:0]  wr_a [2][256];
    logic [15:0] wr_d [2][256];
    int          wr_c [2][256];
    int exp_mag [2][16] = '{
        '{0, 1, 4, 9, 16, 25, 36, 25, 64, 81, 100, 121, 144, 169, 196, 225},
        '{0, 0, 639, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
    };

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_zero(input string who, input logic [7:0] sm, input logic st,
                            input logic rd, input logic we, input logic dn,
                            input logic [4:0] ad, input logic [15:0] dd);
        chk_eq({who, "_sample"}, 32'(sm), 0);
        chk_eq({who, "_start"},  32'(st), 0);
        chk_eq({who, "_read"},   32'(rd), 0);
        chk_eq({who, "_wen"},    32'(we), 0);
        chk_eq({who, "_done"},   32'(dn), 0);
        chk_eq({who, "_waddr"},  32'(ad), 0);
        chk_eq({who, "_din"},    32'(dd), 0);
    endtask

    task automatic observe(input int i, input logic st, input logic rd, input logic we,
                           input logic dn, input logic [4:0] ad, input logic [15:0] dd);
        if (st && rd)         ovl[i]++;
        if (st && prev_st[i]) cons_st[i]++;
        if (rd && prev_rd[i]) cons_rd[i]++;
        prev_st[i] = st;
        prev_rd[i] = rd;
        if (st) begin
            n_start[i]++;
            if (in_sweep[i]) st_in_sw[i]++;
        end
        if (rd) begin
            if (!in_sweep[i]) st_pre_rd[i] = n_start[i];
            in_sweep[i] = 1'b1;
            n_read[i]++;
        end
        if (we && wr_n[i] < 256) begin
            wr_a[i][wr_n[i]] = ad;
            wr_d[i][wr_n[i]] = dd;
            wr_c[i][wr_n[i]] = cyc;
            wr_n[i]++;
        end
        if (dn) begin
            n_done[i]++;
            done_c[i]   = cyc;
            in_sweep[i] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        observe(0, g_dut[0].fft_start, g_dut[0].fft_read, g_dut[0].bram_w_en,
                g_dut[0].sweep_done, g_dut[0].bram_w_addr, g_dut[0].bram_d_in);
        observe(1, g_dut[1].fft_start, g_dut[1].fft_read, g_dut[1].bram_w_en,
                g_dut[1].sweep_done, g_dut[1].bram_w_addr, g_dut[1].bram_d_in);
    endtask

    task automatic chk_sweep(input int i, input int base, input string who);
        for (int j = 0; j < 16; j++) begin
            chk_eq($sformatf("%s_addr%0d", who, j), 32'(wr_a[i][base + j]), j);
            chk_eq($sformatf("%s_data%0d", who, j), 32'(wr_d[i][base + j]), exp_mag[i][j]);
        end
    endtask

    initial begin
        int mark;
        bit seen2;
        for (int i = 0; i < 2; i++) begin
            n_start[i] = 0; n_read[i] = 0; st_pre_rd[i] = 0; st_in_sw[i] = 0;
            n_done[i] = 0; done_c[i] = 0; ovl[i] = 0; cons_st[i] = 0; cons_rd[i] = 0;
            wr_n[i] = 0; in_sweep[i] = 0; prev_st[i] = 0; prev_rd[i] = 0;
            for (int k = 0; k < 16; k++) begin
                ov_re[i][k] = 16'(k);
                ov_im[i][k] = 16'sd0;
            end
        end
        ov_re[0][5] = 16'sd3;     ov_im[0][5] = 16'sd4;
        ov_re[0][7] = -16'sd4;    ov_im[0][7] = -16'sd3;
        ov_re[1][2] = -16'sd32768; ov_im[1][2] = -16'sd32768;
        ov_re[1][3] = 16'sd160;   ov_im[1][3] = 16'sd0;

        // Reset state with a non-zero ADC word present.
        adc = 8'hA5;
        repeat (3) @(negedge clk);
        chk_zero("rst0", g_dut[0].sample, g_dut[0].fft_start, g_dut[0].fft_read, g_dut[0].bram_w_en,
                 g_dut[0].sweep_done, g_dut[0].bram_w_addr, g_dut[0].bram_d_in);
        chk_zero("rst1", g_dut[1].sample, g_dut[1].fft_start, g_dut[1].fft_read, g_dut[1].bram_w_en,
                 g_dut[1].sweep_done, g_dut[1].bram_w_addr, g_dut[1].bram_d_in);

        // Release; the first start is visible in the cycle after the first edge.
        rst_n = 2'b11;
        #1;
        chk_eq("start_at_release", 32'(g_dut[0].fft_start), 0);
        step();
        chk_eq("first_start0", 32'(g_dut[0].fft_start), 1);
        chk_eq("first_sample0", 32'(g_dut[0].sample), 32'h A5);
        chk_eq("first_start1", 32'(g_dut[1].fft_start), 1);
        adc = 8'h3C;

        seen2 = 1'b0;
        for (int k = 0; k < 2000 && !(n_done[0] > 0 && n_done[1] > 0); k++) begin
            step();
            if (!seen2 && g_dut[0].fft_start) begin
                seen2 = 1'b1;
                chk_eq("second_sample", 32'(g_dut[0].sample), 32'h3C);
            end
        end
        chk_eq("sweep1_reached", 32'(n_done[0] > 0 && n_done[1] > 0), 1);

        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("starts_before_sweep%0d", i), st_pre_rd[i], 8);
            chk_eq($sformatf("reads%0d", i), n_read[i], 16);
            chk_eq($sformatf("start_in_sweep%0d", i), st_in_sw[i], 0);
            chk_eq($sformatf("writes%0d", i), wr_n[i], 16);
            chk_sweep(i, 0, $sformatf("sw%0d", i));
            chk_eq($sformatf("done_count%0d", i), n_done[i], 1);
            chk_eq($sformatf("done_timing%0d", i), done_c[i], wr_c[i][15] + 1);
            chk_eq($sformatf("sweep_span%0d", i), wr_c[i][15] - wr_c[i][0], 135);
        end

        for (int k = 0; k < 30 && !(n_start[0] > 8 && n_start[1] > 8); k++) step();
        chk_eq("resume0", 32'(n_start[0] > 8), 1);
        chk_eq("resume1", 32'(n_start[1] > 8), 1);

        // Abort the second sweep of instance 0 while it waits on bin 9.
        for (int k = 0; k < 1000 && !(g_dut[0].fft_read && g_dut[0].bram_w_addr == 5'd9); k++) step();
        chk_eq("reached_bin9_read", 32'(g_dut[0].fft_read && g_dut[0].bram_w_addr == 5'd9), 1);
        step();
        chk_eq("din_before_abort", 32'(g_dut[0].bram_d_in), 64);
        rst_n[0] = 1'b0;
        #1;
        chk_zero("abort", g_dut[0].sample, g_dut[0].fft_start, g_dut[0].fft_read, g_dut[0].bram_w_en,
                 g_dut[0].sweep_done, g_dut[0].bram_w_addr, g_dut[0].bram_d_in);
        mark = wr_n[0];
        step();
        step();
        chk_eq("no_write_in_reset", wr_n[0], mark);
        rst_n[0] = 1'b1;
        in_sweep[0] = 1'b0; n_start[0] = 0; st_pre_rd[0] = 0; n_done[0] = 0;

        for (int k = 0; k < 1000 && n_done[0] == 0; k++) step();
        chk_eq("sweep2_reached", n_done[0], 1);
        chk_eq("starts_after_abort", st_pre_rd[0], 8);
        chk_eq("writes_after_abort", wr_n[0] - mark, 16);
        chk_sweep(0, mark, "rsw");

        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("start_read_overlap%0d", i), ovl[i], 0);
            chk_eq($sformatf("start_back_to_back%0d", i), cons_st[i], 0);
            chk_eq($sformatf("read_back_to_back%0d", i), cons_rd[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
